// File: rtl/z180_spi_master_pkg.sv
// ============================================================================
//  Module   : z180_spi_master_pkg
//  Purpose  : Shared constants and types for the Z180 SD-card SPI master.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package z180_spi_master_pkg;

    localparam logic [7:0] c_PORT_DATA = 8'hF2;
    localparam logic [7:0] c_PORT_CTRL = 8'hF3;

    localparam int c_CTL_SSEL    = 0;
    localparam int c_CTL_FAST    = 1;
    localparam int c_CTL_IEN     = 2;
    localparam int c_CTL_OVR_CLR = 6;

    localparam int c_STS_SSEL = 0;
    localparam int c_STS_FAST = 1;
    localparam int c_STS_IEN  = 2;
    localparam int c_STS_IRQF = 4;
    localparam int c_STS_DET  = 5;
    localparam int c_STS_OVR  = 6;
    localparam int c_STS_BUSY = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } spi_state_t;

    function automatic logic [7:0] pack_status(
        input logic busy,
        input logic ovr,
        input logic det,
        input logic irqf,
        input logic ien,
        input logic fast,
        input logic ssel
    );
        logic [7:0] s;
        s             = '0;
        s[c_STS_BUSY] = busy;
        s[c_STS_OVR]  = ovr;
        s[c_STS_DET]  = det;
        s[c_STS_IRQF] = irqf;
        s[c_STS_IEN]  = ien;
        s[c_STS_FAST] = fast;
        s[c_STS_SSEL] = ssel;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// ============================================================================
//  Module   : spi_clk_div
//  Purpose  : SPI half-period counter; emits a one-cycle pulse at phase end.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_div #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == '0);

    // Reloading on the tick itself keeps every phase exactly i_div cycles long.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load || o_tick) begin
            r_cnt <= i_div - CNT_W'(1);
        end else if (i_run) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/z180_spi_master.sv
// ============================================================================
//  Module   : z180_spi_master
//  Purpose  : Byte-wide SPI mode-0 master for the SD socket (ports F2/F3).
//             Optional interrupt output enabled by defining SPI_IRQ_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z180_spi_master
    import z180_spi_master_pkg::*;
#(
    parameter int SLOW_DIV = 23,
    parameter int FAST_DIV = 1
) (
    input  logic       phi,
    input  logic       reset_n,
    input  logic       wr_tick,
    input  logic       rd_tick,
    input  logic       reg_sel,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       sd_miso,
    input  logic       sd_det,
    output logic       sd_mosi,
    output logic       sd_clk,
    output logic       sd_ssel_n,
    output logic       busy
`ifdef SPI_IRQ_EN
    ,
    output logic       irq
`endif
);

    localparam int                 c_CNT_W = $clog2(SLOW_DIV + 1);
    localparam logic [c_CNT_W-1:0] c_SLOW  = c_CNT_W'(SLOW_DIV);
    localparam logic [c_CNT_W-1:0] c_FAST  = c_CNT_W'(FAST_DIV);

    spi_state_t         r_state;
    spi_state_t         w_state_nxt;
    logic               w_load;
    logic               w_run;
    logic               w_tick;
    logic [c_CNT_W-1:0] r_div;
    logic [c_CNT_W-1:0] w_div_sel;
    logic [c_CNT_W-1:0] w_div;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx;
    logic [2:0]         r_bit;
    logic               r_ssel, r_fast, r_ien, r_ovr, r_irqf;
    logic               w_ssel_nxt, w_fast_nxt, w_ien_nxt, w_ovr_nxt, w_irqf_nxt;
    logic               w_is_data;
    logic               w_is_ctrl;
    logic               w_data_wr;

    assign w_is_data = (reg_sel == c_PORT_DATA[0]);
    assign w_is_ctrl = (reg_sel == c_PORT_CTRL[0]);
    assign w_data_wr = wr_tick && w_is_data;
    assign w_run     = (r_state == S_LOW) || (r_state == S_HIGH);
    assign w_div_sel = r_fast ? c_FAST : c_SLOW;
    // The divider sees the live selection only while idle; a transfer keeps its own copy.
    assign w_div     = (r_state == S_IDLE) ? w_div_sel : r_div;

    spi_clk_div #(
        .CNT_W (c_CNT_W)
    ) u_clk_div (
        .clk    (phi),
        .rst_n  (reset_n),
        .i_load (w_load),
        .i_run  (w_run),
        .i_div  (w_div),
        .o_tick (w_tick)
    );

    always_ff @(posedge phi) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_data_wr) begin
                    w_state_nxt = S_LOW;
                    w_load      = 1'b1;
                end
            end
            S_LOW: begin
                if (w_tick) w_state_nxt = S_HIGH;
            end
            S_HIGH: begin
                if (w_tick) w_state_nxt = (r_bit == 3'd7) ? S_DONE : S_LOW;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge phi) begin
        if (!reset_n) begin
            r_shift <= 8'hFF;
            r_rx    <= 8'hFF;
            r_bit   <= 3'd0;
            r_div   <= c_SLOW;
        end else begin
            if (w_load) begin
                r_shift <= din;
                r_div   <= w_div_sel;
            end
            if ((r_state == S_HIGH) && w_tick) begin
                r_shift <= {r_shift[6:0], sd_miso};
                r_bit   <= r_bit + 3'd1;
            end
            if (r_state == S_DONE) begin
                r_rx <= r_shift;
            end
        end
    end

    always_comb begin
        w_ssel_nxt = r_ssel;
        w_fast_nxt = r_fast;
        w_ien_nxt  = r_ien;
        w_ovr_nxt  = r_ovr;
        w_irqf_nxt = r_irqf;
        if (wr_tick && w_is_ctrl) begin
            w_ssel_nxt = din[c_CTL_SSEL];
            w_fast_nxt = din[c_CTL_FAST];
            w_ien_nxt  = din[c_CTL_IEN];
            if (din[c_CTL_OVR_CLR]) w_ovr_nxt = 1'b0;
        end
        if (w_data_wr && (r_state != S_IDLE)) w_ovr_nxt = 1'b1;
        // Completion wins over a data read landing in the DONE cycle.
        if (rd_tick && w_is_data) w_irqf_nxt = 1'b0;
        if (r_state == S_DONE)    w_irqf_nxt = 1'b1;
    end

    always_ff @(posedge phi) begin
        if (!reset_n) begin
            r_ssel <= 1'b0;
            r_fast <= 1'b0;
            r_ien  <= 1'b0;
            r_ovr  <= 1'b0;
            r_irqf <= 1'b0;
        end else begin
            r_ssel <= w_ssel_nxt;
            r_fast <= w_fast_nxt;
            r_ien  <= w_ien_nxt;
            r_ovr  <= w_ovr_nxt;
            r_irqf <= w_irqf_nxt;
        end
    end

`ifdef SPI_IRQ_EN
    logic r_irq;

    always_ff @(posedge phi) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irqf_nxt && w_ien_nxt;
        end
    end

    assign irq = r_irq;
`endif

    assign busy      = (r_state != S_IDLE);
    assign sd_clk    = (r_state == S_HIGH);
    assign sd_mosi   = w_run ? r_shift[7] : 1'b1;
    assign sd_ssel_n = ~r_ssel;
    assign dout      = w_is_ctrl ? pack_status(busy, r_ovr, sd_det, r_irqf, r_ien, r_fast, r_ssel)
                                 : r_rx;

endmodule

`default_nettype wire

// File: tb/tb_z180_spi_master.sv
// ============================================================================
//  Module   : tb_z180_spi_master
//  Purpose  : Randomised self-checking bench for z180_spi_master.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z180_spi_master;

    localparam int SLOW = 23;
    localparam int FAST = 1;

    logic       phi = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_tick = 1'b0;
    logic       rd_tick = 1'b0;
    logic       reg_sel = 1'b0;
    logic [7:0] din = 8'h00;
    logic       sd_miso = 1'b1;
    logic       sd_det = 1'b0;
    logic [7:0] dout;
    logic       sd_mosi, sd_clk, sd_ssel_n, busy;
`ifdef SPI_IRQ_EN
    logic       irq;
`endif

    z180_spi_master #(
        .SLOW_DIV (SLOW),
        .FAST_DIV (FAST)
    ) dut (
        .phi       (phi),
        .reset_n   (reset_n),
        .wr_tick   (wr_tick),
        .rd_tick   (rd_tick),
        .reg_sel   (reg_sel),
        .din       (din),
        .dout      (dout),
        .sd_miso   (sd_miso),
        .sd_det    (sd_det),
        .sd_mosi   (sd_mosi),
        .sd_clk    (sd_clk),
        .sd_ssel_n (sd_ssel_n),
        .busy      (busy)
`ifdef SPI_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 phi = ~phi;

    int checks   = 0;
    int failures = 0;

    // Reference register state, updated from the programmer's view of the block.
    logic       m_ssel = 1'b0, m_fast = 1'b0, m_ien = 1'b0, m_ovr = 1'b0, m_irqf = 1'b0;
    logic [7:0] m_rx = 8'hFF;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status(input logic b);
        return {b, m_ovr, sd_det, m_irqf, 1'b0, m_ien, m_fast, m_ssel};
    endfunction

    task automatic step();
        @(posedge phi);
        #1;
    endtask

    task automatic model_reset();
        m_ssel = 1'b0; m_fast = 1'b0; m_ien = 1'b0; m_ovr = 1'b0; m_irqf = 1'b0;
        m_rx   = 8'hFF;
    endtask

    task automatic model_ctl(input logic [7:0] v);
        m_ssel = v[0];
        m_fast = v[1];
        m_ien  = v[2];
        if (v[6]) m_ovr = 1'b0;
    endtask

    task automatic ctl_write(input logic [7:0] v);
        reg_sel = 1'b1; din = v; wr_tick = 1'b1;
        model_ctl(v);
        step();
        wr_tick = 1'b0;
    endtask

    task automatic check_status(input string tag);
        reg_sel = 1'b1;
        #1;
        check_val(tag, dout, exp_status(1'b0));
    endtask

    // One full byte: every cycle's sd_clk/mosi/busy/ssel_n is compared against
    // the phase arithmetic (phase = (c-1)/div, odd phases high, one bit per two phases).
    task automatic do_xfer(input logic [7:0] tx, input int miso_mode, input int ovr_at,
                           input int ctl_at, input logic [7:0] ctl_val, input bit rd_done,
                           output logic [7:0] rx_obs);
        int         d, n, phase;
        int         bad_clk, bad_mosi, bad_busy, bad_ssel;
        logic [7:0] exp_rx;
        logic       e_clk, e_mosi;
        d = m_fast ? FAST : SLOW;
        n = 16 * d + 1;
        bad_clk = 0; bad_mosi = 0; bad_busy = 0; bad_ssel = 0;
        exp_rx = 8'h00;
        reg_sel = 1'b0; din = tx; wr_tick = 1'b1;
        step();
        wr_tick = 1'b0;
        for (int c = 1; c <= n; c++) begin
            phase  = (c - 1) / d;
            e_clk  = (c <= 16 * d) && (phase % 2 == 1);
            e_mosi = (c <= 16 * d) ? tx[7 - phase / 2] : 1'b1;
            if (sd_clk !== e_clk) bad_clk++;
            if ((c <= 16 * d) && (sd_mosi !== e_mosi)) bad_mosi++;
            if (busy !== 1'b1) bad_busy++;
            if (sd_ssel_n !== ~m_ssel) bad_ssel++;
            case (miso_mode)
                0:       sd_miso = e_mosi;
                1:       sd_miso = 1'b0;
                default: sd_miso = 1'($urandom_range(0, 1));
            endcase
            if ((c <= 16 * d) && (c % (2 * d) == 0)) exp_rx = {exp_rx[6:0], sd_miso};
            if (c == ovr_at) begin
                reg_sel = 1'b0; din = ~tx; wr_tick = 1'b1;
                m_ovr = 1'b1;
            end
            if (c == ctl_at) begin
                reg_sel = 1'b1; din = ctl_val; wr_tick = 1'b1;
                model_ctl(ctl_val);
            end
            if ((c == n) && rd_done) begin
                reg_sel = 1'b0; rd_tick = 1'b1;
                #1;
                check_val("rd_in_done_old", dout, m_rx);
            end
            step();
            wr_tick = 1'b0; rd_tick = 1'b0;
        end
        m_rx   = exp_rx;
        m_irqf = 1'b1;
        check_val("wave_sclk", bad_clk, 0);
        check_val("wave_mosi", bad_mosi, 0);
        check_val("wave_busy", bad_busy, 0);
        check_val("wave_ssel", bad_ssel, 0);
        check_val("busy_after", busy, 1'b0);
`ifdef SPI_IRQ_EN
        check_val("irq_rise", irq, m_ien);
`endif
        check_status("status_done");
        reg_sel = 1'b0;
        #1;
        rx_obs = dout;
        check_val("rx_byte", dout, m_rx);
        rd_tick = 1'b1;
        step();
        rd_tick = 1'b0;
        m_irqf = 1'b0;
`ifdef SPI_IRQ_EN
        check_val("irq_drop", irq, 1'b0);
`endif
        check_status("status_rdclr");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic [7:0] v;
        sd_det  = 1'($urandom_range(0, 1));
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        model_reset();
        check_val("rst_sclk", sd_clk, 1'b0);
        check_val("rst_mosi", sd_mosi, 1'b1);
        check_val("rst_ssel", sd_ssel_n, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_status("rst_status");
        check_val("rst_status_abs", dout, {2'b00, sd_det, 5'b00000});
        reg_sel = 1'b0;
        #1;
        check_val("rst_rx", dout, 8'hFF);
`ifdef SPI_IRQ_EN
        check_val("rst_irq", irq, 1'b0);
`endif

        ctl_write(8'h01);
        check_val("ssel_on", sd_ssel_n, 1'b0);
        do_xfer(8'hA5, 0, 0, 0, 8'h00, 1'b0, rx);
        check_val("loop_a5", rx, 8'hA5);

        ctl_write(8'h03);
        do_xfer(8'h3C, 1, 0, 0, 8'h00, 1'b0, rx);
        check_val("fast_zero", rx, 8'h00);

        do_xfer(8'($urandom), 2, 5, 0, 8'h00, 1'b0, rx);
        ctl_write(8'h41);
        check_status("ovr_clear");

        // Slow byte with a mid-transfer control write: ssel drops now, fast waits.
        do_xfer(8'($urandom), 2, 0, 3, 8'h02, 1'b0, rx);
        do_xfer(8'($urandom), 2, 0, 0, 8'h00, 1'b1, rx);

        ctl_write(8'h07);
        do_xfer(8'hFF, 2, 0, 0, 8'h00, 1'b0, rx);

        for (int i = 0; i < 4; i++) begin
            v = {5'b00000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            ctl_write(v);
            do_xfer(8'($urandom), 2, 0, 0, 8'h00, 1'($urandom_range(0, 1)), rx);
        end

        // Abort in the high phase of bit 4.
        ctl_write(8'h01);
        reg_sel = 1'b0; din = 8'($urandom); wr_tick = 1'b1;
        step();
        wr_tick = 1'b0;
        for (int c = 1; c < 1 + 9 * SLOW; c++) begin
            sd_miso = 1'($urandom_range(0, 1));
            step();
        end
        check_val("abort_pre_sclk", sd_clk, 1'b1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        model_reset();
        check_val("abort_sclk", sd_clk, 1'b0);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_ssel", sd_ssel_n, 1'b1);
        check_status("abort_status");
        reg_sel = 1'b0;
        #1;
        check_val("abort_rx", dout, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
